// File: rtl/mul_div_unit_if.sv
// Operand, control and result signals exchanged between the execute stage
// and the multiply/divide unit. The execute stage is the master and the
// multiply/divide unit is the slave.
interface mul_div_unit_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  MDUControl;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output A, B, MDUControl, Start,
    input  Busy, HI, LO
  );

  modport slave (
    input  A, B, MDUControl, Start,
    output Busy, HI, LO
  );
endinterface

// File: rtl/mul_div_unit.sv
// Multicycle multiply/divide unit that owns the HI/LO registers.
// The arithmetic is computed in a single cycle from latched operands.
// A down-counter only models the latency reported to the stall unit on Busy.
module mul_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic           clk,
  input logic           reset,
  mul_div_unit_if.slave mdu
);

  localparam int MaxCycles = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CountW    = $clog2(MaxCycles + 1);

  typedef enum logic {IDLE, BUSY} stateT;

  stateT              stateQ, stateD;
  logic [CountW-1:0]  countQ, countD;
  logic [31:0]        aQ, aD, bQ, bD;
  logic [2:0]         opQ, opD;
  logic [31:0]        hiQ, hiD, loQ, loD;

  logic [63:0] prodSigned, prodUnsigned;
  logic [31:0] absA, absB, divisorSafe;
  logic [31:0] magQuot, magRem;
  logic [31:0] quotSigned, remSigned;
  logic [31:0] quotUnsigned, remUnsigned;

  // Arithmetic on the latched operands. Signed division runs on magnitudes
  // and then re-applies the signs. This truncates toward zero, gives the
  // remainder the sign of the dividend, and makes 0x80000000 / -1 come out
  // as 0x80000000 remainder 0 without a special case.
  always_comb begin
    prodSigned   = $signed({{32{aQ[31]}}, aQ}) * $signed({{32{bQ[31]}}, bQ});
    prodUnsigned = {32'b0, aQ} * {32'b0, bQ};
    absA         = aQ[31] ? (~aQ + 32'd1) : aQ;
    absB         = bQ[31] ? (~bQ + 32'd1) : bQ;
    divisorSafe  = (absB == 32'd0) ? 32'd1 : absB;
    magQuot      = absA / divisorSafe;
    magRem       = absA % divisorSafe;
    quotSigned   = (aQ[31] ^ bQ[31]) ? (~magQuot + 32'd1) : magQuot;
    remSigned    = aQ[31] ? (~magRem + 32'd1) : magRem;
    quotUnsigned = aQ / ((bQ == 32'd0) ? 32'd1 : bQ);
    remUnsigned  = aQ % ((bQ == 32'd0) ? 32'd1 : bQ);
  end

  // Next-state logic: accept work only in IDLE, count down while BUSY,
  // and commit HI/LO on the last busy cycle (skipped for a zero divisor).
  always_comb begin
    stateD = stateQ;
    countD = countQ;
    aD     = aQ;
    bD     = bQ;
    opD    = opQ;
    hiD    = hiQ;
    loD    = loQ;
    case (stateQ)
      IDLE: begin
        if (mdu.Start) begin
          case (mdu.MDUControl)
            3'd1, 3'd2: begin
              aD     = mdu.A;
              bD     = mdu.B;
              opD    = mdu.MDUControl;
              countD = CountW'(MULT_CYCLES);
              stateD = BUSY;
            end
            3'd3, 3'd4: begin
              aD     = mdu.A;
              bD     = mdu.B;
              opD    = mdu.MDUControl;
              countD = CountW'(DIV_CYCLES);
              stateD = BUSY;
            end
            3'd5:    hiD = mdu.A;
            3'd6:    loD = mdu.A;
            default: ;
          endcase
        end
      end
      BUSY: begin
        countD = countQ - CountW'(1);
        if (countQ == CountW'(1)) begin
          stateD = IDLE;
          case (opQ)
            3'd1: begin
              hiD = prodSigned[63:32];
              loD = prodSigned[31:0];
            end
            3'd2: begin
              hiD = prodUnsigned[63:32];
              loD = prodUnsigned[31:0];
            end
            3'd3: begin
              if (bQ != 32'd0) begin
                hiD = remSigned;
                loD = quotSigned;
              end
            end
            3'd4: begin
              if (bQ != 32'd0) begin
                hiD = remUnsigned;
                loD = quotUnsigned;
              end
            end
            default: ;
          endcase
        end
      end
      default: stateD = IDLE;
    endcase
  end

  // State register with synchronous reset that aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ <= IDLE;
      countQ <= '0;
      aQ     <= '0;
      bQ     <= '0;
      opQ    <= '0;
      hiQ    <= '0;
      loQ    <= '0;
    end else begin
      stateQ <= stateD;
      countQ <= countD;
      aQ     <= aD;
      bQ     <= bD;
      opQ    <= opD;
      hiQ    <= hiD;
      loQ    <= loD;
    end
  end

  assign mdu.Busy = (stateQ == BUSY);
  assign mdu.HI   = hiQ;
  assign mdu.LO   = loQ;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit. It uses directed corner cases
// followed by random operations. Results are compared against an
// arithmetic reference model of HI/LO.
module tb_mul_div_unit;

  logic clk;
  logic reset;
  int   checkCount;
  int   errorCount;
  logic [31:0] modelHi;
  logic [31:0] modelLo;

  mul_div_unit_if mduBus ();

  mul_div_unit #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .mdu  (mduBus.slave)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it if the values differ.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Expected busy length for an opcode accepted in IDLE.
  function automatic int expectedCycles(input logic [2:0] op);
    case (op)
      3'd1, 3'd2: return 5;
      3'd3, 3'd4: return 10;
      default:    return 0;
    endcase
  endfunction

  // Reference model: HI/LO after the operation, from plain 64-bit arithmetic.
  task automatic modelOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, r, p;
    longint unsigned up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (op)
      3'd1: begin
        p = sa * sb;
        modelHi = 32'(p >>> 32);
        modelLo = 32'(p);
      end
      3'd2: begin
        up = {32'b0, a} * {32'b0, b};
        modelHi = 32'(up >> 32);
        modelLo = 32'(up);
      end
      3'd3: begin
        if (b != 32'd0) begin
          q = sa / sb;
          r = sa % sb;
          modelHi = 32'(r);
          modelLo = 32'(q);
        end
      end
      3'd4: begin
        if (b != 32'd0) begin
          modelHi = a % b;
          modelLo = a / b;
        end
      end
      3'd5: modelHi = a;
      3'd6: modelLo = a;
      default: ;
    endcase
  endtask

  // Issues one Start cycle, scrambles the operands afterwards, and
  // optionally pokes Start while busy. Then checks the busy length and HI/LO.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input bit pokeWhileBusy, input string tag);
    int cnt;
    @(negedge clk);
    mduBus.Start      = 1'b1;
    mduBus.MDUControl = op;
    mduBus.A          = a;
    mduBus.B          = b;
    @(posedge clk);
    #1;
    mduBus.Start = 1'b0;
    mduBus.A     = $urandom;
    mduBus.B     = $urandom;
    modelOp(op, a, b);
    cnt = 0;
    while (mduBus.Busy === 1'b1 && cnt < 50) begin
      if (pokeWhileBusy) begin
        mduBus.Start      = 1'b1;
        mduBus.MDUControl = 3'($urandom_range(1, 7));
        mduBus.A          = $urandom;
        mduBus.B          = $urandom;
      end
      cnt++;
      @(posedge clk);
      #1;
    end
    mduBus.Start = 1'b0;
    checkOutput({tag, "_busyLen"}, 64'(cnt), 64'(expectedCycles(op)));
    checkOutput({tag, "_HI"}, {32'b0, mduBus.HI}, {32'b0, modelHi});
    checkOutput({tag, "_LO"}, {32'b0, mduBus.LO}, {32'b0, modelLo});
  endtask

  // Main sequence: reset, directed cases, then random operations.
  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    checkCount = 0;
    errorCount = 0;
    modelHi = '0;
    modelLo = '0;
    reset = 1'b1;
    mduBus.Start      = 1'b0;
    mduBus.MDUControl = 3'd0;
    mduBus.A          = 32'd0;
    mduBus.B          = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_Busy", {63'b0, mduBus.Busy}, 64'd0);
    checkOutput("reset_HI", {32'b0, mduBus.HI}, 64'd0);
    checkOutput("reset_LO", {32'b0, mduBus.LO}, 64'd0);
    reset = 1'b0;

    applyStimulus(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, "mult");
    applyStimulus(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, "multu");
    applyStimulus(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, "div");
    applyStimulus(3'd4, 32'd7, 32'd0, 1'b0, "divuZero");
    applyStimulus(3'd3, 32'h1234, 32'd0, 1'b0, "divZero");
    applyStimulus(3'd6, 32'h1234_5678, 32'd0, 1'b0, "mtlo");
    applyStimulus(3'd5, 32'hCAFE_F00D, 32'd0, 1'b0, "mthi");
    applyStimulus(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "divOvf");
    applyStimulus(3'd3, 32'd7, 32'hFFFF_FFFE, 1'b0, "divNegDivisor");
    applyStimulus(3'd1, 32'h0001_0003, 32'h0002_0005, 1'b1, "multPoked");
    applyStimulus(3'd0, 32'hDEAD_BEEF, 32'd1, 1'b0, "none");
    applyStimulus(3'd7, 32'hDEAD_BEEF, 32'd1, 1'b0, "reserved");

    // Abort a divide in its third busy cycle and restart straight away.
    applyStimulus(3'd5, 32'h5555_AAAA, 32'd0, 1'b0, "mthiPre");
    @(negedge clk);
    mduBus.Start      = 1'b1;
    mduBus.MDUControl = 3'd3;
    mduBus.A          = 32'd1000;
    mduBus.B          = 32'd3;
    @(posedge clk);
    #1;
    mduBus.Start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    modelHi = '0;
    modelLo = '0;
    checkOutput("abort_Busy", {63'b0, mduBus.Busy}, 64'd0);
    checkOutput("abort_HI", {32'b0, mduBus.HI}, 64'd0);
    checkOutput("abort_LO", {32'b0, mduBus.LO}, 64'd0);
    applyStimulus(3'd1, 32'd12345, 32'hFFFF_FF00, 1'b0, "multAfterReset");

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
      applyStimulus(op, a, b, 1'($urandom_range(0, 1)), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-003 SHALL have port A, input, 32 bits: forwarded rs operand, the same value presented to the execute-stage ALU A input.
REQ-004 SHALL have port B, input, 32 bits: forwarded rt operand, the same value presented to the ALU B input.
REQ-005 SHALL have port MDUControl, input, 3 bits: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
REQ-006 SHALL have port Start, input, 1 bit: decoder qualifier; the operation is valid in this cycle.
REQ-007 SHALL have port Busy, output, 1 bit: a multicycle operation is in progress; consumed by the hazard/stall unit.
REQ-008 SHALL have port HI, output, 32 bits: architectural HI register value, for mfhi.
REQ-009 SHALL have port LO, output, 32 bits: architectural LO register value, for mflo.
REQ-010 SHALL have parameter MULT_CYCLES, default 5: Busy duration for mult/multu.
REQ-011 SHALL have parameter DIV_CYCLES, default 10: Busy duration for div/divu.

Function
REQ-012 SHALL implement a two-state FSM, IDLE and BUSY, plus a down-counter sized for DIV_CYCLES.
REQ-013 In IDLE, Start=1 with MDUControl 1-4 SHALL latch A, B and the op, load the counter with MULT_CYCLES or DIV_CYCLES, and go to BUSY.
REQ-014 Busy SHALL equal 1 exactly while the state is BUSY: from the cycle after the Start edge for N cycles, where N is the op's cycle count.
REQ-015 In BUSY, the counter SHALL decrement each cycle; at count 1 the edge SHALL write HI/LO, go to IDLE and drop Busy.
REQ-016 HI/LO SHALL be visible on the outputs in the first cycle with Busy=0 after an operation.
REQ-017 mult SHALL produce the signed 64-bit product of A and B; multu SHALL produce the unsigned product; HI = bits [63:32], LO = bits [31:0].
REQ-018 div SHALL produce a signed quotient truncated toward zero in LO and the remainder in HI, with the remainder taking the sign of the dividend.
REQ-019 divu SHALL produce the unsigned quotient in LO and the unsigned remainder in HI.
REQ-020 div or divu with B=0 SHALL still hold Busy for DIV_CYCLES and SHALL leave HI/LO unchanged.
REQ-021 div of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-022 mthi (5) or mtlo (6) with Start=1 in IDLE SHALL write A into HI or LO at that edge, with no Busy cycles.
REQ-023 Start=1 while BUSY SHALL be ignored for all opcodes, and HI/LO SHALL not be corrupted; stall logic prevents this case.
REQ-024 Start=1 with MDUControl 0 or 7 SHALL have no effect.
REQ-025 Operand latching SHALL make the result independent of A/B changes after the Start edge.
REQ-026 Results SHALL be computed from the latched operands; the delay is modelled by the counter, and the arithmetic itself may be single-cycle combinational.

Reset
REQ-027 reset=1 at an edge SHALL force IDLE, counter=0, Busy=0, HI=0 and LO=0, with priority over Start.
REQ-028 reset asserted mid-operation SHALL abort it: HI/LO become 0 and the aborted result is never written.
REQ-029 Start in the first cycle after reset deasserts SHALL be accepted normally.

Verification
REQ-030 mult, A=0xFFFFFFFF, B=2, Start for 1 cycle -> Busy=1 for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
REQ-031 multu, same operands -> HI=0x00000001, LO=0xFFFFFFFE after 5 Busy cycles.
REQ-032 div, A=-7 (0xFFFFFFF9), B=2 -> Busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 7/0 -> Busy for 10 cycles, HI/LO unchanged.
REQ-033 mtlo with A=0x12345678 -> LO=0x12345678 the next cycle, Busy stays 0; a div Start during a mult's Busy window -> ignored, mult result intact.
REQ-034 reset pulsed in cycle 3 of a div -> Busy=0, HI=LO=0 next cycle; a mult issued immediately after completes in 5 cycles.
